// File: rtl/audio_sample_player.sv
// -----------------------------------------------------------------------------
// audio_sample_player
//
// Plays mono samples from an external ROM to a stereo (NUM_CH) audio codec.
// Each codec handshake reads one input frame, waits for the ROM sample at the
// current address, computes one output frame according to the latched mode
// (passthrough / loop / one-shot / mix), writes it, and advances the address.
//
// Ports
//   CLOCK_50     sole clock, rising edge
//   reset_n      asynchronous active-low reset
//   mode         00 passthrough, 01 loop, 10 one-shot, 11 mix
//   start        one-cycle pulse: restart playback at address 0
//   atten        arithmetic right shift applied to the ROM sample
//   read_ready   codec holds an input frame
//   write_ready  codec accepts an output frame
//   readdata     codec input frame, channel 0 in the LSBs
//   rom_q        ROM sample (ROM_LAT clocks after rom_addr)
//   read         one-cycle pulse consuming readdata
//   write        one-cycle pulse presenting writedata
//   writedata    registered output frame, channel 0 in the LSBs
//   rom_addr     registered ROM address
//   done         one-shot playback reached the last sample
// -----------------------------------------------------------------------------
module audio_sample_player #(
  parameter int DATA_W  = 24,
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 65536,
  parameter int ROM_LAT = 1
) (
  input  logic                     CLOCK_50,
  input  logic                     reset_n,
  input  logic [1:0]               mode,
  input  logic                     start,
  input  logic [2:0]               atten,
  input  logic                     read_ready,
  input  logic                     write_ready,
  input  logic [NUM_CH*DATA_W-1:0] readdata,
  input  logic [DATA_W-1:0]        rom_q,
  output logic                     read,
  output logic                     write,
  output logic [NUM_CH*DATA_W-1:0] writedata,
  output logic [ADDR_W-1:0]        rom_addr,
  output logic                     done
);

  localparam int                BUS_W     = NUM_CH * DATA_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [1:0]        LAT_LAST  = 2'(ROM_LAT - 1);

  localparam logic [1:0] MODE_PASS    = 2'b00;
  localparam logic [1:0] MODE_LOOP    = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;
  localparam logic [1:0] MODE_MIX     = 2'b11;

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_LAT   = 2'd1,
    S_CALC  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          lat_cnt_q, lat_cnt_d;
  logic [1:0]          mode_q, mode_d;
  logic [BUS_W-1:0]    rdata_q, rdata_d;
  logic                pend_q, pend_d;
  logic                read_q, read_d;
  logic                write_q, write_d;
  logic [BUS_W-1:0]    wdata_q, wdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                done_q, done_d;

  logic                handshake;
  logic                addr_update;
  logic [BUS_W-1:0]    calc_data;
  logic signed [DATA_W-1:0] rom_sh;
  logic [DATA_W-1:0]   in_ch;
  logic [DATA_W:0]     mix_sum;

  assign handshake   = (state_q == S_WAIT) && read_ready && write_ready;
  assign addr_update = (state_q == S_WRITE) && write_ready;

  // ---------------------------------------------------------------------------
  // State register (plus all datapath flops)
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_WAIT;
      lat_cnt_q <= '0;
      mode_q    <= MODE_PASS;
      rdata_q   <= '0;
      pend_q    <= 1'b0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      addr_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      mode_q    <= mode_d;
      rdata_q   <= rdata_d;
      pend_q    <= pend_d;
      read_q    <= read_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      addr_q    <= addr_d;
      done_q    <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_WAIT:  if (handshake)             state_d = S_LAT;
      S_LAT:   if (lat_cnt_q == LAT_LAST) state_d = S_CALC;
      S_CALC:                             state_d = S_WRITE;
      S_WRITE: if (write_ready)           state_d = S_WAIT;
      default:                            state_d = S_WAIT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Per-channel sample computation from the latched frame and mode
  // ---------------------------------------------------------------------------
  always_comb begin
    calc_data = '0;
    in_ch     = '0;
    mix_sum   = '0;
    rom_sh    = $signed(rom_q) >>> atten;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      in_ch   = rdata_q[ch*DATA_W +: DATA_W];
      // One guard bit keeps the sum exact; dropping bit 0 halves it.
      mix_sum = {in_ch[DATA_W-1], in_ch} + {rom_sh[DATA_W-1], rom_sh};
      unique case (mode_q)
        MODE_PASS:    calc_data[ch*DATA_W +: DATA_W] = in_ch;
        MODE_LOOP:    calc_data[ch*DATA_W +: DATA_W] = rom_sh;
        MODE_ONESHOT: calc_data[ch*DATA_W +: DATA_W] = done_q ? '0 : rom_sh;
        MODE_MIX:     calc_data[ch*DATA_W +: DATA_W] = mix_sum[DATA_W:1];
        default:      calc_data[ch*DATA_W +: DATA_W] = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    lat_cnt_d = '0;
    mode_d    = mode_q;
    rdata_d   = rdata_q;
    pend_d    = pend_q;
    read_d    = 1'b0;
    write_d   = 1'b0;
    wdata_d   = wdata_q;
    addr_d    = addr_q;
    done_d    = done_q;

    if (handshake) begin
      read_d  = 1'b1;
      mode_d  = mode;
      rdata_d = readdata;
    end

    if (state_q == S_LAT) begin
      lat_cnt_d = lat_cnt_q + 2'd1;
    end

    if (state_q == S_CALC) begin
      wdata_d = calc_data;
    end

    if (state_q == S_WAIT) begin
      // Restart is immediate while idle; the pending flag is never set here.
      if (start) begin
        addr_d = '0;
        done_d = 1'b0;
        pend_d = 1'b0;
      end
    end else if (addr_update) begin
      write_d = 1'b1;
      if (pend_q || start) begin
        addr_d = '0;
        done_d = 1'b0;
        pend_d = 1'b0;
      end else begin
        unique case (mode_q)
          MODE_PASS: addr_d = '0;
          MODE_LOOP, MODE_MIX: addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
          MODE_ONESHOT: begin
            if (addr_q == LAST_ADDR) done_d = 1'b1;
            else                     addr_d = addr_q + 1'b1;
          end
          default: addr_d = addr_q;
        endcase
      end
    end else if (start) begin
      pend_d = 1'b1;
    end
  end

  assign read      = read_q;
  assign write     = write_q;
  assign writedata = wdata_q;
  assign rom_addr  = addr_q;
  assign done      = done_q;

endmodule

// File: doc/audio_sample_player.md
AUDIO_SAMPLE_PLAYER -- requirements
Module: audio_sample_player

Interface
REQ-001 Parameters (one per line: name, default, meaning) SHALL be:
  DATA_W, 24, sample width in bits, two's complement.
  NUM_CH, 2, number of codec channels; channel 0 occupies the LSBs of the packed buses.
  ADDR_W, 16, ROM address width.
  DEPTH, 65536, samples played, 2 <= DEPTH <= 2^ADDR_W.
  ROM_LAT, 1, ROM read latency in clocks, 1..3.
REQ-002 Ports (one per line: name, direction, width, meaning) SHALL be:
  CLOCK_50  in  1  sole clock; all logic on its rising edge.
  reset_n  in  1  asynchronous, active-low reset.
  mode  in  2  00 passthrough, 01 loop, 10 one-shot, 11 mix.
  start  in  1  one-cycle pulse that restarts playback at address 0.
  atten  in  3  ROM sample attenuation, arithmetic right shift by atten.
  read_ready  in  1  codec holds input samples.
  write_ready  in  1  codec accepts output samples.
  readdata  in  NUM_CH*DATA_W  codec input samples, packed.
  rom_q  in  DATA_W  mono ROM sample, applied to every channel.
  read  out  1  one-cycle pulse that consumes readdata.
  write  out  1  one-cycle pulse that presents writedata.
  writedata  out  NUM_CH*DATA_W  codec output samples, packed, registered.
  rom_addr  out  ADDR_W  registered ROM address.
  done  out  1  one-shot playback has finished.

Function
REQ-003 The FSM SHALL have four states: S_WAIT, S_LAT, S_CALC and S_WRITE.
REQ-004 S_WAIT SHALL behave as follows:
  - When read_ready && write_ready is high, the block latches readdata and mode.
  - It pulses read for exactly 1 cycle.
  - It then goes to S_LAT.
REQ-005 S_LAT SHALL count ROM_LAT cycles with rom_addr held stable, then go to S_CALC.
REQ-006 S_CALC SHALL register writedata for each channel from the latched mode:
  - 00: the latched readdata.
  - 01 or 10: rom_q >>> atten.
  - 10 with done=1: 0.
  - 11: the sign-extended (DATA_W+1)-bit sum of the channel input and (rom_q >>> atten), arithmetic-shifted right by 1 and truncated to DATA_W.
  Mix mode with done is not applicable, because done is only set in mode 10.
REQ-007 S_WRITE SHALL wait for write_ready, pulse write for 1 cycle, update the address per REQ-008, and return to S_WAIT.
REQ-008 The address update SHALL follow these rules:
  - 00: rom_addr becomes 0.
  - 01 or 11: rom_addr increments, and wraps from DEPTH-1 to 0.
  - 10: rom_addr increments; at DEPTH-1 it holds and done becomes 1.
REQ-009 A start pulse in any state SHALL set a pending flag.
  - The flag is consumed at the next address update: rom_addr becomes 0 and done becomes 0, overriding increment, wrap and hold.
  - If start arrives while in S_WAIT, rom_addr becomes 0 and done becomes 0 on the next cycle.
REQ-010 A mode change SHALL take effect only when latched in S_WAIT; no sample in flight is altered.
REQ-011 read and write SHALL never both be high in the same cycle.
REQ-012 Minimum latency from the read pulse to the write pulse SHALL be ROM_LAT+2 cycles.
REQ-013 read_ready falling while in S_LAT, S_CALC or S_WRITE SHALL have no effect.

Reset
REQ-014 While reset_n=0, the outputs and state SHALL be held immediately at these values:
  - state S_WAIT
  - rom_addr 0
  - writedata 0
  - read 0, write 0, done 0
  - latched mode 00
  - start pending flag clear.
REQ-015 On reset_n deassertion mid-operation, no read or write pulse SHALL be emitted until a fresh S_WAIT handshake occurs.

Verification
REQ-016 The bench SHALL cover these directed scenarios:
  - Passthrough: mode=00, readdata={24'h123456,24'hFEDCBA}, both readies high -> 1 read pulse, then after 3 cycles (ROM_LAT=1) writedata equals readdata, 1 write pulse, rom_addr=0.
  - Loop wrap: mode=01, DEPTH=4, 6 sample handshakes -> rom_addr sequence 1,2,3,0,1,2; writedata equals the ROM sample at each prior address.
  - One-shot end: mode=10, DEPTH=4, 5 handshakes -> done=1 after the 4th, rom_addr held at 3, 5th writedata=0; a start pulse -> done=0 and rom_addr=0.
  - Mix/attenuation: mode=11, atten=1, rom_q=24'h400000, readdata channel=24'hC00000 -> writedata channel=24'hF00000; and rom_q=24'h7FFFFF, input=24'h7FFFFF, atten=0 -> 24'h7FFFFF, with no overflow.
  - Reset mid-sample: reset_n low during S_LAT -> all outputs 0 immediately; after release, write stays low until a new handshake.
  - Start coincident with wrap: mode=01 at rom_addr=DEPTH-1, start pulsed in S_CALC -> rom_addr=0 after write, pending flag cleared, next advance gives 1.
